// File: rtl/movimento_ctrl.sv
// Grid movement controller: latches direction requests and steps a position one cell per tick.
// Optional macro MOVIMENTO_WRAP_EN: stepping past an edge wraps around instead of stopping.
module movimento_ctrl #(
    parameter int GRID_W = 40,
    parameter int GRID_H = 30,
    parameter int X0     = 20,
    parameter int Y0     = 15
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       N,
    input  logic       S,
    input  logic       L,
    input  logic       O,
    input  logic       tick,
    output logic [5:0] pos_x,
    output logic [4:0] pos_y,
    output logic [1:0] dir,
    output logic       moved,
    output logic       ativo,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [1:0] D_N = 2'd0;
    localparam logic [1:0] D_S = 2'd1;
    localparam logic [1:0] D_L = 2'd2;
    localparam logic [1:0] D_O = 2'd3;

    localparam logic [6:0] X_LIM = 7'(GRID_W);
    localparam logic [5:0] Y_LIM = 6'(GRID_H);
    localparam logic [5:0] X_MAX = 6'(GRID_W - 1);
    localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);

    state_t     state_q;
    logic [5:0] pos_x_q;
    logic [4:0] pos_y_q;
    logic [1:0] dir_q;
    logic [1:0] pend_q;
    logic       moved_q;
    logic       ativo_q;

    logic       req_any;
    logic [1:0] req_dir;
    logic       req_ok;
    logic [1:0] step_dir;
    logic [6:0] x_inc;
    logic [5:0] y_inc;
    logic [5:0] nx;
    logic [4:0] ny;
    logic       edge_hit;

    always_comb begin
        req_any = N | S | L | O;
        req_dir = D_O;
        if (N)      req_dir = D_N;
        else if (S) req_dir = D_S;
        else if (L) req_dir = D_L;
        // Opposite pairs differ only in bit 0 (N/S = 0/1, L/O = 2/3).
        req_ok   = req_any && (req_dir != (dir_q ^ 2'b01));
        step_dir = req_ok ? req_dir : pend_q;
    end

    always_comb begin
        x_inc    = {1'b0, pos_x_q} + 7'd1;
        y_inc    = {1'b0, pos_y_q} + 6'd1;
        nx       = pos_x_q;
        ny       = pos_y_q;
        edge_hit = 1'b0;
        case (step_dir)
            D_N: begin
                if (pos_y_q == 5'd0) begin
                    edge_hit = 1'b1;
                    ny       = Y_MAX;
                end else begin
                    ny = pos_y_q - 5'd1;
                end
            end
            D_S: begin
                if (y_inc >= Y_LIM) begin
                    edge_hit = 1'b1;
                    ny       = 5'd0;
                end else begin
                    ny = y_inc[4:0];
                end
            end
            D_L: begin
                if (x_inc >= X_LIM) begin
                    edge_hit = 1'b1;
                    nx       = 6'd0;
                end else begin
                    nx = x_inc[5:0];
                end
            end
            default: begin
                if (pos_x_q == 6'd0) begin
                    edge_hit = 1'b1;
                    nx       = X_MAX;
                end else begin
                    nx = pos_x_q - 6'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pos_x_q <= 6'(X0);
            pos_y_q <= 5'(Y0);
            dir_q   <= D_N;
            pend_q  <= D_N;
            moved_q <= 1'b0;
            ativo_q <= 1'b0;
        end else begin
            moved_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_any) begin
                        dir_q   <= req_dir;
                        pend_q  <= req_dir;
                        state_q <= ST_RUN;
                        ativo_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        dir_q  <= step_dir;
                        pend_q <= step_dir;
                        if (edge_hit) begin
`ifdef MOVIMENTO_WRAP_EN
                            pos_x_q <= nx;
                            pos_y_q <= ny;
                            moved_q <= 1'b1;
`else
                            state_q <= ST_STOP;
                            ativo_q <= 1'b0;
`endif
                        end else begin
                            pos_x_q <= nx;
                            pos_y_q <= ny;
                            moved_q <= 1'b1;
                        end
                    end else if (req_ok) begin
                        pend_q <= req_dir;
                    end
                end
                default: begin
                    state_q <= ST_STOP;
                end
            endcase
        end
    end

    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign dir     = dir_q;
    assign moved   = moved_q;
    assign ativo   = ativo_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_movimento_ctrl.sv
// Self-checking bench for movimento_ctrl: expected positions are queued per tick and
// compared whenever the DUT pulses moved.
module tb_movimento_ctrl;

  logic       clk_50;
  logic       rst_n;
  logic       n_r, s_r, l_r, o_r, tick;
  logic [5:0] pos_x;
  logic [4:0] pos_y;
  logic [1:0] dir;
  logic       moved;
  logic       ativo;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  int moved_cnt = 0;

  // {pos_x, pos_y, dir}
  logic [12:0] exp_q[$];

  movimento_ctrl dut (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .N      (n_r),
    .S      (s_r),
    .L      (l_r),
    .O      (o_r),
    .tick   (tick),
    .pos_x  (pos_x),
    .pos_y  (pos_y),
    .dir    (dir),
    .moved  (moved),
    .ativo  (ativo),
    .state_o(state_o)
  );

  // clock / reset
  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard
  always @(negedge clk_50) begin
    if (rst_n && moved === 1'b1) begin
      logic [12:0] e;
      moved_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_moved: got pos=(%0d,%0d) dir=%0d, required no moved pulse",
                 pos_x, pos_y, dir);
      end else begin
        e = exp_q.pop_front();
        if ({pos_x, pos_y, dir} !== e) begin
          errors++;
          $display("FAIL step_result: got pos=(%0d,%0d) dir=%0d, required pos=(%0d,%0d) dir=%0d",
                   pos_x, pos_y, dir, e[12:7], e[6:2], e[1:0]);
        end
      end
    end
  end

  // drivers
  task automatic step(input logic n, input logic s, input logic l, input logic o, input logic t);
    @(posedge clk_50); #2;
    n_r = n; s_r = s; l_r = l; o_r = o; tick = t;
    @(posedge clk_50); #2;
    n_r = 1'b0; s_r = 1'b0; l_r = 1'b0; o_r = 1'b0; tick = 1'b0;
  endtask

  task automatic push(input int x, input int y, input int d);
    exp_q.push_back({6'(x), 5'(y), 2'(d)});
  endtask

  task automatic apply_reset();
    @(posedge clk_50); #3;
    rst_n = 1'b0;
    #25;
    @(negedge clk_50);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    n_r = 1'b0; s_r = 1'b0; l_r = 1'b0; o_r = 1'b0; tick = 1'b0;
    #35;
    checks++;
    if ({pos_x, pos_y} !== {6'd20, 5'd15}) begin
      errors++;
      $display("FAIL reset_pos: got (%0d,%0d), required (20,15)", pos_x, pos_y);
    end
    checks++;
    if ({dir, moved, ativo, state_o} !== 6'b00_0_0_00) begin
      errors++;
      $display("FAIL reset_ctrl: got dir=%0d moved=%0b ativo=%0b state=%0d, required 0 0 0 0",
               dir, moved, ativo, state_o);
    end
    @(negedge clk_50);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_tick();
    step(0, 0, 0, 0, 1);
    @(negedge clk_50);
    checks++;
    if ({pos_x, pos_y, state_o, ativo} !== {6'd20, 5'd15, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL idle_tick: got pos=(%0d,%0d) state=%0d ativo=%0b, required (20,15) 0 0",
               pos_x, pos_y, state_o, ativo);
    end
  endtask

  task automatic test_east_steps();
    int cnt0;
    cnt0 = moved_cnt;
    step(0, 0, 1, 0, 0);
    @(negedge clk_50);
    checks++;
    if ({state_o, ativo, dir} !== {2'd1, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL idle_to_run: got state=%0d ativo=%0b dir=%0d, required 1 1 2",
               state_o, ativo, dir);
    end
    for (int i = 0; i < 3; i++) begin
      push(21 + i, 15, 2);
      step(0, 0, 0, 0, 1);
    end
    @(negedge clk_50);
    @(negedge clk_50);
    checks++;
    if (moved_cnt - cnt0 != 3) begin
      errors++;
      $display("FAIL east_moved_count: got %0d, required 3", moved_cnt - cnt0);
    end
    checks++;
    if ({pos_x, pos_y, dir, ativo} !== {6'd23, 5'd15, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL east_final: got pos=(%0d,%0d) dir=%0d ativo=%0b, required (23,15) 2 1",
               pos_x, pos_y, dir, ativo);
    end
  endtask

  task automatic test_reject_opposite();
    push(23, 14, 0);
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    push(23, 13, 0);
    step(0, 0, 0, 0, 1);
    @(negedge clk_50);
    checks++;
    if ({dir, pos_y} !== {2'd0, 5'd13}) begin
      errors++;
      $display("FAIL reject_opposite: got dir=%0d y=%0d, required dir=0 y=13", dir, pos_y);
    end
    push(23, 12, 0);
    step(0, 0, 0, 0, 1);
    @(negedge clk_50);
    checks++;
    if (pos_y !== 5'd12) begin
      errors++;
      $display("FAIL pending_kept: got y=%0d, required 12", pos_y);
    end
  endtask

  task automatic test_priority();
    push(24, 12, 2);
    step(0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0);
    push(24, 11, 0);
    step(0, 0, 0, 0, 1);
    @(negedge clk_50);
    checks++;
    if ({dir, pos_x, pos_y} !== {2'd0, 6'd24, 5'd11}) begin
      errors++;
      $display("FAIL priority_n_over_o: got dir=%0d pos=(%0d,%0d), required 0 (24,11)",
               dir, pos_x, pos_y);
    end
  endtask

  task automatic test_last_wins();
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    push(23, 11, 3);
    step(0, 0, 0, 0, 1);
    @(negedge clk_50);
    checks++;
    if ({dir, pos_x} !== {2'd3, 6'd23}) begin
      errors++;
      $display("FAIL last_pulse_wins: got dir=%0d x=%0d, required dir=3 x=23", dir, pos_x);
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0, 0);
    @(posedge clk_50); #5;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pos_x, pos_y, dir, moved, ativo, state_o} !== {6'd20, 5'd15, 2'd0, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL async_reset: got pos=(%0d,%0d) dir=%0d moved=%0b ativo=%0b state=%0d, required (20,15) 0 0 0 0",
               pos_x, pos_y, dir, moved, ativo, state_o);
    end
    #6;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 1);
    @(negedge clk_50);
    checks++;
    if ({pos_x, pos_y, state_o} !== {6'd20, 5'd15, 2'd0}) begin
      errors++;
      $display("FAIL tick_after_reset: got pos=(%0d,%0d) state=%0d, required (20,15) 0",
               pos_x, pos_y, state_o);
    end
  endtask

  task automatic test_edge();
    apply_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      push(20, 14 - i, 0);
      step(0, 0, 0, 0, 1);
    end
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 19; i++) begin
      push(21 + i, 5, 2);
      step(0, 0, 0, 0, 1);
    end
    @(negedge clk_50);
    checks++;
    if ({pos_x, pos_y, dir} !== {6'd39, 5'd5, 2'd2}) begin
      errors++;
      $display("FAIL edge_setup: got pos=(%0d,%0d) dir=%0d, required (39,5) 2", pos_x, pos_y, dir);
    end
`ifdef MOVIMENTO_WRAP_EN
    push(0, 5, 2);
    step(0, 0, 0, 0, 1);
    @(negedge clk_50);
    checks++;
    if ({pos_x, pos_y, moved, ativo} !== {6'd0, 5'd5, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_east: got pos=(%0d,%0d) moved=%0b ativo=%0b, required (0,5) 1 1",
               pos_x, pos_y, moved, ativo);
    end
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      push(0, 4 - i, 0);
      step(0, 0, 0, 0, 1);
    end
    push(0, 29, 0);
    step(0, 0, 0, 0, 1);
    @(negedge clk_50);
    checks++;
    if ({pos_x, pos_y, state_o} !== {6'd0, 5'd29, 2'd1}) begin
      errors++;
      $display("FAIL wrap_north: got pos=(%0d,%0d) state=%0d, required (0,29) 1",
               pos_x, pos_y, state_o);
    end
`else
    begin
      int cnt0;
      step(0, 0, 0, 0, 1);
      @(negedge clk_50);
      checks++;
      if ({pos_x, pos_y, moved, ativo, state_o} !== {6'd39, 5'd5, 1'b0, 1'b0, 2'd2}) begin
        errors++;
        $display("FAIL edge_stop: got pos=(%0d,%0d) moved=%0b ativo=%0b state=%0d, required (39,5) 0 0 2",
                 pos_x, pos_y, moved, ativo, state_o);
      end
      cnt0 = moved_cnt;
      step(0, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      @(negedge clk_50);
      @(negedge clk_50);
      checks++;
      if ({pos_x, pos_y, ativo, state_o} !== {6'd39, 5'd5, 1'b0, 2'd2} || moved_cnt != cnt0) begin
        errors++;
        $display("FAIL stop_terminal: got pos=(%0d,%0d) ativo=%0b state=%0d extra_moved=%0d, required (39,5) 0 2 0",
                 pos_x, pos_y, ativo, state_o, moved_cnt - cnt0);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_idle_tick();
    test_east_steps();
    test_reject_opposite();
    test_priority();
    test_last_wins();
    test_async_reset();
    test_edge();
    repeat (3) @(negedge clk_50);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding steps, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
